// File: rtl/register_file_2r1w.sv
// Two-read, one-write register file for the 16-bit multicycle datapath.
// Optional hardwired-zero register 0, stack pointer with reset value, and same-cycle write bypass.
module register_file_2r1w #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 4,
   parameter int ZERO_REG = 1,
   parameter int SP_INDEX = 15,
   parameter logic [DATA_WIDTH-1:0] SP_RESET = 16'hFFFE,
   parameter int BYPASS = 1
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [ADDR_WIDTH-1:0] read_addr1,
   input  logic [ADDR_WIDTH-1:0] read_addr2,
   input  logic                  write_en,
   input  logic [ADDR_WIDTH-1:0] write_addr,
   input  logic [DATA_WIDTH-1:0] write_data,
   output logic [DATA_WIDTH-1:0] read_data1,
   output logic [DATA_WIDTH-1:0] read_data2,
   output logic [DATA_WIDTH-1:0] sp_value
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] SP_ADDR = ADDR_WIDTH'(SP_INDEX);

   logic [DATA_WIDTH-1:0] regs [DEPTH];
   logic                  write_ok;
   logic                  bypass_live;

   // Writes to the zero register are discarded; reset always wins over a write.
   assign write_ok    = write_en && !((ZERO_REG != 0) && (write_addr == '0));
   assign bypass_live = (BYPASS != 0) && write_en && reset;

   always_ff @(posedge clock) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs[i] <= (ADDR_WIDTH'(i) == SP_ADDR) ? SP_RESET : '0;
         end
      end else if (write_ok) begin
         regs[write_addr] <= write_data;
      end
   end

   // Zero-register override is applied last so it beats both storage and bypass.
   always_comb begin
      read_data1 = regs[read_addr1];
      if (bypass_live && (read_addr1 == write_addr)) read_data1 = write_data;
      if ((ZERO_REG != 0) && (read_addr1 == '0)) read_data1 = '0;

      read_data2 = regs[read_addr2];
      if (bypass_live && (read_addr2 == write_addr)) read_data2 = write_data;
      if ((ZERO_REG != 0) && (read_addr2 == '0)) read_data2 = '0;
   end

   assign sp_value = regs[SP_ADDR];

endmodule
